sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Responder on the word-addressed RAM side of the memory path. Accepts one 16-bit word request at a time: word address, write data, byte-lane enables and write enable.
- Sequences an external asynchronous 16-bit SRAM (active-low CE/OE/WE/UB/LB) with a programmable number of wait states.
- Returns read data and a one-cycle ack. Sits between the CPU byte-lane adapter and the SRAM pins; the tristate buffer lives at top level.

Parameters:
AW, 16, word-address width driven to the SRAM
WAIT_STATES, 1, extra SRAM access cycles beyond the first (0..15)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req  in  1  request; sampled only in IDLE while ack=0
addr  in  AW  word address
wdata  in  16  write data, bits 15:8 upper lane, 7:0 lower lane
be  in  2  byte enables; be[1]=upper lane, be[0]=lower lane
we  in  1  1=write, 0=read
rdata  out  16  registered read data
ack  out  1  one-cycle completion pulse
busy  out  1  high in any state other than IDLE
err  out  1  sticky write-verify mismatch (optional feature)
sram_addr  out  AW  SRAM address
sram_dq_out  out  16  SRAM write data
sram_dq_oe  out  1  drive enable for SRAM data bus
sram_dq_in  in  16  SRAM data bus input
sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes

Behaviour:
- Reset: one clock, synchronous, active-low (clk, rst_n).
  - On rst_n=0 at a clock edge, state=IDLE and the in-flight access is abandoned.
  - All strobes go high and sram_dq_oe=0.
  - ack=0, busy=0, rdata=0, err=0, sram_addr=0, sram_dq_out=0.
  - Reset asserted mid-write releases we_n in the same edge; no ack is issued for the abandoned access.
- Accept: in IDLE, req=1 and ack=0 latches addr/wdata/be/we into internal registers. Inputs are don't-care afterwards. req while busy, or in the ack cycle, is ignored; the requester drops req when it sees ack.
- be=0: no-op. Goes IDLE to DONE with no strobe asserted, and ack is pulsed the edge after acceptance (latency 2). rdata is unchanged.
- States: IDLE, WSETUP, ACCESS, WHOLD, VERIFY (optional), DONE is implied by ack.
  - ACCESS uses a 4-bit counter loaded with WAIT_STATES and lasts WAIT_STATES+1 cycles.
- Read: IDLE to ACCESS.
  - Throughout ACCESS: ce_n=0, oe_n=0, ub_n=~be[1], lb_n=~be[0], sram_addr=latched addr, dq_oe=0.
  - On the final ACCESS edge, sram_dq_in is captured into rdata with disabled lanes zeroed, state goes to IDLE and ack=1.
  - Latency from accepting edge to ack-high cycle: WAIT_STATES+2 cycles.
- Write: IDLE to WSETUP (1 cycle), then ACCESS (WAIT_STATES+1 cycles), then WHOLD (1 cycle), then IDLE with ack=1.
  - dq_oe=1 and sram_dq_out=latched wdata from WSETUP through WHOLD.
  - ce_n=0 and lane strobes active from WSETUP through WHOLD.
  - we_n=0 only in ACCESS; oe_n=1 throughout.
  - Latency WAIT_STATES+4; rdata is unchanged.
- Strobes and sram_addr are registered outputs, so no combinational path from req to pins.
- busy = (state != IDLE); ack is high only in the first IDLE cycle after completion.
- The counter never wraps. WAIT_STATES=0 gives a single ACCESS cycle.

Optional Feature:
SRAM_CTRL_VERIFY_EN
- Defined: after WHOLD, the write enters VERIFY, a read cycle of WAIT_STATES+1 cycles with the same strobe rules as a read.
  - On the final edge, enabled lanes of sram_dq_in are compared with the latched wdata; a mismatch sets err, which is sticky until reset.
  - ack follows VERIFY, so write latency becomes 2*WAIT_STATES+5. rdata is not updated by verify.
- Undefined: VERIFY state is absent, err is tied 0, and write latency stays WAIT_STATES+4.

Test Plan:
- Reset mid-write (WAIT_STATES=3, drop rst_n in second ACCESS cycle) -> next cycle: we_n=1, ce_n=1, dq_oe=0, busy=0, no ack.
- Full-word write addr=0x0012, wdata=0xBEEF, be=2'b11, WAIT_STATES=1 -> we_n low exactly 2 cycles, ub_n=lb_n=0, ack 5 cycles after accept. Readback of 0x0012 -> rdata=0xBEEF, ack 3 cycles after accept.
- Upper-lane read, SRAM model word 0xA55A, be=2'b10 -> ub_n=0, lb_n=1, rdata=0xA500.
- Lower-lane write wdata=0x00C3, be=2'b01 over existing 0x1234 -> model word 0x12C3, sram_lb_n=0, sram_ub_n=1.
- req held high across ack, plus req with be=0 -> exactly one access per req assertion. be=0 request gets ack at latency 2 with no strobe toggled.
- SRAM_CTRL_VERIFY_EN defined, model forces bit 0 stuck at 0, write 0x0001 be=2'b11 -> err=1 after ack at latency 7 (WAIT_STATES=1) and stays 1 through later accesses.

Source files
------------

// File: rtl/sram_ctrl.sv
// Single-word controller for an asynchronous 16-bit SRAM with programmable wait states.
// Define SRAM_CTRL_VERIFY_EN to add a read-back verify after each write and a sticky err flag.
module sram_ctrl #(
    parameter int AW          = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    input  logic [1:0]    be,
    input  logic          we,
    output logic [15:0]   rdata,
    output logic          ack,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] sram_addr,
    output logic [15:0]   sram_dq_out,
    output logic          sram_dq_oe,
    input  logic [15:0]   sram_dq_in,
    output logic          sram_ce_n,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE, WSETUP, ACCESS, WHOLD, DONE
`ifdef SRAM_CTRL_VERIFY_EN
        , VERIFY
`endif
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [1:0]  be_q;
    logic        we_q;
    logic        accept, done, load_cnt, cur_we;
    logic [1:0]  cur_be;
    logic        on_ce, on_oe, on_we, on_dq;

    function automatic logic [15:0] lane_mask(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    // Strobes are registered from the next state, so pins line up with the state they belong to.
    always_comb begin
        accept   = (state == IDLE) && req && !ack;
        cur_we   = accept ? we : we_q;
        cur_be   = accept ? be : be_q;
        state_nx = state;
        done     = 1'b0;
        load_cnt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (be == 2'b00) begin
                        state_nx = DONE;
                    end else if (we) begin
                        state_nx = WSETUP;
                    end else begin
                        state_nx = ACCESS;
                        load_cnt = 1'b1;
                    end
                end
            end
            WSETUP: begin
                state_nx = ACCESS;
                load_cnt = 1'b1;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    if (we_q) begin
                        state_nx = WHOLD;
                    end else begin
                        state_nx = IDLE;
                        done     = 1'b1;
                    end
                end
            end
            WHOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
                state_nx = VERIFY;
                load_cnt = 1'b1;
`else
                state_nx = IDLE;
                done     = 1'b1;
`endif
            end
`ifdef SRAM_CTRL_VERIFY_EN
            VERIFY: begin
                if (cnt == 4'd0) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
`endif
            DONE: begin
                state_nx = IDLE;
                done     = 1'b1;
            end
            default: state_nx = IDLE;
        endcase

        on_ce = (state_nx != IDLE) && (state_nx != DONE);
        on_oe = (state_nx == ACCESS) && !cur_we;
`ifdef SRAM_CTRL_VERIFY_EN
        if (state_nx == VERIFY) on_oe = 1'b1;
`endif
        on_we = (state_nx == ACCESS) && cur_we;
        on_dq = (state_nx == WSETUP) || (state_nx == WHOLD) || on_we;
    end

`ifdef SRAM_CTRL_VERIFY_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            be_q        <= 2'b00;
            we_q        <= 1'b0;
            ack         <= 1'b0;
            rdata       <= 16'h0000;
            sram_addr   <= '0;
            sram_dq_out <= 16'h0000;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
`ifdef SRAM_CTRL_VERIFY_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            ack   <= done;
            if (accept) begin
                sram_addr   <= addr;
                sram_dq_out <= wdata;
                be_q        <= be;
                we_q        <= we;
            end
            if (load_cnt) begin
                cnt <= 4'(WAIT_STATES);
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == ACCESS && cnt == 4'd0 && !we_q) begin
                rdata <= sram_dq_in & lane_mask(be_q);
            end
`ifdef SRAM_CTRL_VERIFY_EN
            if (state == VERIFY && cnt == 4'd0 &&
                ((sram_dq_in ^ sram_dq_out) & lane_mask(be_q)) != 16'h0000) begin
                err_q <= 1'b1;
            end
`endif
            sram_ce_n  <= !on_ce;
            sram_oe_n  <= !on_oe;
            sram_we_n  <= !on_we;
            sram_ub_n  <= !(on_ce && cur_be[1]);
            sram_lb_n  <= !(on_ce && cur_be[0]);
            sram_dq_oe <= on_dq;
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: behavioural SRAM, reference memory model, randomized traffic.
// Honours SRAM_CTRL_VERIFY_EN to select the expected write timing and err behaviour.
module tb_sram_ctrl;

    localparam int AW = 16;
    localparam int W  = 1;
`ifdef SRAM_CTRL_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          req;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    be;
    logic          we;
    logic [15:0]   rdata;
    logic          ack, busy, err;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_ctrl #(.AW(AW), .WAIT_STATES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wdata(wdata), .be(be), .we(we),
        .rdata(rdata), .ack(ack), .busy(busy), .err(err),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM; rd_mask models stuck-at-0 data bits on reads.
    logic [15:0] mem [256];
    logic [15:0] rd_mask;
    logic [15:0] bus_w;
    assign bus_w      = sram_dq_oe ? sram_dq_out : 16'hFFFF;
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? (mem[sram_addr[7:0]] & rd_mask) : 16'hDEAD;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= bus_w[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= bus_w[7:0];
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
        logic [1:0]    b;
        logic [15:0]   rd;
        logic          e;
        int            lat;
        int            n_ce, n_oe, n_we, n_dq;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_mem [256];
    logic [15:0] ref_rdata;
    logic        ref_err;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
        end
    endtask

    function automatic logic [15:0] mask_of(input logic [1:0] b);
        return {{8{b[1]}}, {8{b[0]}}};
    endfunction

    // Reference model: compute the expected outcome of one request, then drive it.
    task automatic issue(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] b,
                         input logic w, input bit hold);
        exp_t        e;
        logic [15:0] m;
        bit          got;
        m   = mask_of(b);
        e.a = a; e.d = d; e.b = b;
        if (b == 2'b00) begin
            e.lat = 2; e.n_ce = 0; e.n_oe = 0; e.n_we = 0; e.n_dq = 0;
        end else if (w) begin
            ref_mem[a[7:0]] = (ref_mem[a[7:0]] & ~m) | (d & m);
            if (VERIFY_ON && ((ref_mem[a[7:0]] & rd_mask & m) != (d & m))) ref_err = 1'b1;
            e.lat  = VERIFY_ON ? 2 * W + 5 : W + 4;
            e.n_ce = VERIFY_ON ? 2 * W + 4 : W + 3;
            e.n_oe = VERIFY_ON ? W + 1 : 0;
            e.n_we = W + 1;
            e.n_dq = W + 3;
        end else begin
            ref_rdata = ref_mem[a[7:0]] & m & rd_mask;
            e.lat = W + 2; e.n_ce = W + 1; e.n_oe = W + 1; e.n_we = 0; e.n_dq = 0;
        end
        e.rd = ref_rdata;
        e.e  = ref_err;
        q.push_back(e);
        @(negedge clk);
        req = 1'b1; addr = a; wdata = d; be = b; we = w;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack want ack for addr 0x%0h", a);
        end
        if (hold) begin
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        addr = 16'($urandom); wdata = 16'($urandom); be = 2'($urandom); we = 1'($urandom);
    endtask

    // Monitor: counts pin activity per transaction and scores it when ack appears.
    int   cyc = 0, acc_cyc = 0;
    int   c_ce, c_oe, c_we, c_dq, c_lane, c_badaddr, c_baddata, c_badlane;
    bit   prev_busy = 1'b0;
    exp_t me;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy && !prev_busy) begin
                acc_cyc = cyc;
                c_ce = 0; c_oe = 0; c_we = 0; c_dq = 0; c_lane = 0;
                c_badaddr = 0; c_baddata = 0; c_badlane = 0;
            end
            prev_busy = busy;
            if (!sram_ce_n) c_ce++;
            if (!sram_oe_n) c_oe++;
            if (!sram_we_n) c_we++;
            if (sram_dq_oe) c_dq++;
            if (!sram_ub_n || !sram_lb_n) c_lane++;
            if (q.size() > 0) begin
                if (!sram_ce_n && sram_addr != q[0].a) c_badaddr++;
                if (!sram_ce_n && {~sram_ub_n, ~sram_lb_n} != q[0].b) c_badlane++;
                if (!sram_we_n && sram_dq_out != q[0].d) c_baddata++;
            end
            if (ack) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_ack: got ack want none (queue empty)");
                end else begin
                    me = q.pop_front();
                    check("latency", cyc - acc_cyc + 1, me.lat);
                    check("rdata", int'(rdata), int'(me.rd));
                    check("err", int'(err), int'(me.e));
                    check("ce_cycles", c_ce, me.n_ce);
                    check("oe_cycles", c_oe, me.n_oe);
                    check("we_cycles", c_we, me.n_we);
                    check("dq_oe_cycles", c_dq, me.n_dq);
                    check("lane_cycles", c_lane, me.n_ce);
                    check("addr_errs", c_badaddr, 0);
                    check("lane_errs", c_badlane, 0);
                    check("wdata_errs", c_baddata, 0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; addr = '0; wdata = 16'h0; be = 2'b00; we = 1'b0;
        rd_mask = 16'hFFFF; ref_rdata = 16'h0; ref_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", int'(ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ce_n", int'(sram_ce_n), 1);
        check("rst_oe_n", int'(sram_oe_n), 1);
        check("rst_we_n", int'(sram_we_n), 1);
        check("rst_ub_lb", int'({sram_ub_n, sram_lb_n}), 3);
        check("rst_dq_oe", int'(sram_dq_oe), 0);
        check("rst_rdata", int'(rdata), 0);
        check("rst_err", int'(err), 0);
        check("rst_sram_addr", int'(sram_addr), 0);
        check("rst_dq_out", int'(sram_dq_out), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) issue(AW'(i), 16'($urandom), 2'b11, 1'b1, 1'b0);

        issue(16'h0012, 16'hBEEF, 2'b11, 1'b1, 1'b0);
        issue(16'h0012, 16'h0000, 2'b11, 1'b0, 1'b0);
        issue(16'h0003, 16'hA55A, 2'b11, 1'b1, 1'b0);
        issue(16'h0003, 16'h0000, 2'b10, 1'b0, 1'b0);
        issue(16'h0007, 16'h1234, 2'b11, 1'b1, 1'b0);
        issue(16'h0007, 16'h00C3, 2'b01, 1'b1, 1'b1);
        check("lane_write_word", int'(mem[7]), 32'h12C3);
        issue(16'h0007, 16'h0000, 2'b11, 1'b0, 1'b1);
        issue(16'h0005, 16'hFFFF, 2'b00, 1'b1, 1'b1);
        issue(16'h0005, 16'h0000, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++)
            issue(16'($urandom_range(0, 31)), 16'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom));
        repeat (4) @(negedge clk);
        for (int i = 0; i < 32; i++) check("mem_contents", int'(mem[i]), int'(ref_mem[i]));

        rd_mask = 16'hFFFE;
        issue(16'h0009, 16'h0001, 2'b11, 1'b1, 1'b0);
        check("stuck_err", int'(err), int'(VERIFY_ON));
        for (int i = 0; i < 10; i++)
            issue(16'($urandom_range(0, 31)), 16'($urandom), 2'($urandom), 1'($urandom),
                  1'b0);
        check("stuck_err_sticky", int'(err), int'(VERIFY_ON));

        // Abandon a write in its second ACCESS cycle.
        @(negedge clk);
        req = 1'b1; addr = 16'h0004; wdata = 16'h5555; be = 2'b11; we = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("midwr_busy", int'(busy), 1);
        repeat (2) @(negedge clk);
        check("midwr_in_access", int'(sram_we_n), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midwr_we_n", int'(sram_we_n), 1);
        check("midwr_ce_n", int'(sram_ce_n), 1);
        check("midwr_dq_oe", int'(sram_dq_oe), 0);
        check("midwr_busy_after", int'(busy), 0);
        check("midwr_ack", int'(ack), 0);
        check("midwr_err", int'(err), 0);
        check("midwr_rdata", int'(rdata), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midwr_no_ack", int'(ack), 0);
        end
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
